// File: rtl/usb32_os_event_monitor_pkg.sv
// Shared types and constants for the USB 3.2 ordered-set event monitor.
// Optional snapshot register is enabled by defining USB32_OS_MON_SNAPSHOT_EN.
package usb32_os_mon_pkg;

  localparam int unsigned NUM_OS_TYPES = 6;
  localparam int unsigned OS_TYPE_W    = 3;

  typedef enum logic [2:0] {
    OS_NONE = 3'd0,
    OS_TSEQ = 3'd1,
    OS_TS1  = 3'd2,
    OS_TS2  = 3'd3,
    OS_IDLE = 3'd4,
    OS_SKP  = 3'd5,
    OS_LBPM = 3'd6,
    OS_RSVD = 3'd7
  } os_type_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_MET     = 2'd2,
    ST_TIMEOUT = 2'd3
  } mon_state_e;

  // Bit offset of the counter for type k (1..6) inside the packed counter bus.
  function automatic int unsigned os_slice(input int unsigned k, input int unsigned cnt_width);
    return (k - 1) * cnt_width;
  endfunction

endpackage

// File: rtl/usb32_os_event_monitor_if.sv
// Event/configuration inputs and counter/status outputs of the OS event monitor.
// snap/snap_cnt are only functional when USB32_OS_MON_SNAPSHOT_EN is defined.
interface usb32_os_event_monitor_if #(
  parameter int unsigned NUM_LANES = 2,
  parameter int unsigned CNT_WIDTH = 16
);
  import usb32_os_mon_pkg::*;

  logic [NUM_LANES-1:0]              lane_en;
  logic [NUM_LANES-1:0]              os_valid;
  logic [OS_TYPE_W*NUM_LANES-1:0]    os_type;
  logic                              clr;
  logic                              arm;
  logic [OS_TYPE_W-1:0]              arm_target;
  logic                              snap;
  logic [NUM_OS_TYPES*CNT_WIDTH-1:0] cnt_out;
  logic [CNT_WIDTH-1:0]              mismatch_cnt;
  logic [OS_TYPE_W-1:0]              run_type;
  logic [CNT_WIDTH-1:0]              run_len;
  logic                              target_met;
  logic                              timeout;
  logic [1:0]                        mon_state;
  logic [NUM_OS_TYPES*CNT_WIDTH-1:0] snap_cnt;

  modport master (
    output lane_en, os_valid, os_type, clr, arm, arm_target, snap,
    input  cnt_out, mismatch_cnt, run_type, run_len, target_met, timeout, mon_state, snap_cnt
  );

  modport slave (
    input  lane_en, os_valid, os_type, clr, arm, arm_target, snap,
    output cnt_out, mismatch_cnt, run_type, run_len, target_met, timeout, mon_state, snap_cnt
  );

endinterface

// File: rtl/usb32_os_event_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; also exposes its next value.
module usb32_sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_cnt,
  output logic [WIDTH-1:0] o_cnt_nxt_c
);

  logic [WIDTH-1:0] r_cnt;

  always_comb begin
    o_cnt_nxt_c = r_cnt;
    if (i_clr) begin
      o_cnt_nxt_c = '0;
    end else if (i_inc && (r_cnt != '1)) begin
      o_cnt_nxt_c = r_cnt + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else        r_cnt <= o_cnt_nxt_c;
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/usb32_os_event_monitor.sv
// Multi-lane ordered-set event monitor: per-type counters, run tracking and wait/timeout FSM.
// Define USB32_OS_MON_SNAPSHOT_EN to build the snap_cnt snapshot register.
module usb32_os_event_monitor
  import usb32_os_mon_pkg::*;
#(
  parameter int unsigned NUM_LANES      = 2,
  parameter int unsigned CNT_WIDTH      = 16,
  parameter int unsigned RUN_THRESH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 3000
) (
  input logic                      clk,
  input logic                      rst_n,
  usb32_os_event_monitor_if.slave  bus
);

  localparam int unsigned TMR_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned LAST_TICK = TIMEOUT_CYCLES - 1;
  localparam int unsigned CBUS_W    = NUM_OS_TYPES * CNT_WIDTH;

  logic [NUM_LANES-1:0] w_en_valid;
  logic                 w_any_valid;
  logic                 w_aligned;
  logic                 w_mismatch;
  logic [OS_TYPE_W-1:0] w_t;

  // Classify the cycle as aligned / mismatch / quiet over the enabled lanes.
  always_comb begin
    logic found;
    logic same;
    found       = 1'b0;
    same        = 1'b1;
    w_t         = '0;
    w_en_valid  = bus.os_valid & bus.lane_en;
    w_any_valid = |w_en_valid;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (bus.lane_en[i]) begin
        if (!found) begin
          w_t   = bus.os_type[OS_TYPE_W*i +: OS_TYPE_W];
          found = 1'b1;
        end else if (bus.os_type[OS_TYPE_W*i +: OS_TYPE_W] != w_t) begin
          same = 1'b0;
        end
      end
    end
    w_aligned  = found && (w_en_valid == bus.lane_en) && same &&
                 (w_t != 3'(OS_NONE)) && (w_t != 3'(OS_RSVD));
    w_mismatch = w_any_valid && !w_aligned;
  end

  logic [CNT_WIDTH-1:0] w_cnt     [NUM_OS_TYPES];
  logic [CNT_WIDTH-1:0] w_cnt_nxt [NUM_OS_TYPES];
  logic [CBUS_W-1:0]    w_cnt_pk;
  logic [CBUS_W-1:0]    w_cnt_nxt_pk;

  for (genvar k = 0; k < NUM_OS_TYPES; k++) begin : g_type_cnt
    usb32_sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_clr       (bus.clr),
      .i_inc       (w_aligned && (w_t == 3'(k + 1))),
      .o_cnt       (w_cnt[k]),
      .o_cnt_nxt_c (w_cnt_nxt[k])
    );
  end

  usb32_sat_counter #(.WIDTH(CNT_WIDTH)) u_mismatch_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clr       (bus.clr),
    .i_inc       (w_mismatch),
    .o_cnt       (bus.mismatch_cnt),
    .o_cnt_nxt_c ()
  );

  always_comb begin
    w_cnt_pk     = '0;
    w_cnt_nxt_pk = '0;
    for (int unsigned k = 0; k < NUM_OS_TYPES; k++) begin
      w_cnt_pk[os_slice(k + 1, CNT_WIDTH) +: CNT_WIDTH]     = w_cnt[k];
      w_cnt_nxt_pk[os_slice(k + 1, CNT_WIDTH) +: CNT_WIDTH] = w_cnt_nxt[k];
    end
  end

  assign bus.cnt_out = w_cnt_pk;

  logic [OS_TYPE_W-1:0] r_run_type, w_run_type_nxt;
  logic [CNT_WIDTH-1:0] r_run_len,  w_run_len_nxt;

  // SKP is transparent to runs; any mismatch breaks the run.
  always_comb begin
    w_run_type_nxt = r_run_type;
    w_run_len_nxt  = r_run_len;
    if (bus.clr || w_mismatch) begin
      w_run_type_nxt = '0;
      w_run_len_nxt  = '0;
    end else if (w_aligned && (w_t != 3'(OS_SKP))) begin
      if (w_t == r_run_type) begin
        if (r_run_len != '1) w_run_len_nxt = r_run_len + CNT_WIDTH'(1);
      end else begin
        w_run_type_nxt = w_t;
        w_run_len_nxt  = CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run_type <= '0;
      r_run_len  <= '0;
    end else begin
      r_run_type <= w_run_type_nxt;
      r_run_len  <= w_run_len_nxt;
    end
  end

  mon_state_e           r_state, w_state_nxt;
  logic [TMR_WIDTH-1:0] r_timer, w_timer_nxt;
  logic [OS_TYPE_W-1:0] r_target, w_target_nxt;
  logic                 r_target_met, r_timeout;

  // Wait FSM; met is judged against the run as updated this cycle and beats timeout.
  always_comb begin
    w_state_nxt  = r_state;
    w_timer_nxt  = r_timer;
    w_target_nxt = r_target;
    if (bus.clr) begin
      w_state_nxt = ST_IDLE;
      w_timer_nxt = '0;
    end else if (bus.arm) begin
      w_state_nxt  = ST_ARMED;
      w_timer_nxt  = '0;
      w_target_nxt = bus.arm_target;
    end else if (r_state == ST_ARMED) begin
      if ((w_run_type_nxt == r_target) && (w_run_len_nxt >= CNT_WIDTH'(RUN_THRESH))) begin
        w_state_nxt = ST_MET;
      end else if (r_timer == TMR_WIDTH'(LAST_TICK)) begin
        w_state_nxt = ST_TIMEOUT;
      end else begin
        w_timer_nxt = r_timer + TMR_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_timer      <= '0;
      r_target     <= '0;
      r_target_met <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_timer      <= w_timer_nxt;
      r_target     <= w_target_nxt;
      r_target_met <= (w_state_nxt == ST_MET);
      r_timeout    <= (w_state_nxt == ST_TIMEOUT);
    end
  end

  assign bus.run_type   = r_run_type;
  assign bus.run_len    = r_run_len;
  assign bus.target_met = r_target_met;
  assign bus.timeout    = r_timeout;
  assign bus.mon_state  = r_state;

`ifdef USB32_OS_MON_SNAPSHOT_EN
  logic [CBUS_W-1:0] r_snap_cnt;

  // Next counter values are already zero under clr, so clr and clr+snap both load zeros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_snap_cnt <= '0;
    else if (bus.clr || bus.snap) r_snap_cnt <= w_cnt_nxt_pk;
  end

  assign bus.snap_cnt = r_snap_cnt;
`else
  logic w_snap_unused;
  assign w_snap_unused = bus.snap | (|w_cnt_nxt_pk);
  assign bus.snap_cnt  = '0;
`endif

endmodule

// File: tb/tb_usb32_os_event_monitor.sv
// Randomized + directed bench for usb32_os_event_monitor against a behavioural model.
module tb_usb32_os_event_monitor;

  localparam int unsigned NL = 2;
  localparam int unsigned CW = 4;
  localparam int unsigned RT = 8;
  localparam int unsigned TO = 40;
  localparam int          CMAX = (1 << CW) - 1;

  logic clk;
  logic rst_n;

  usb32_os_event_monitor_if #(.NUM_LANES(NL), .CNT_WIDTH(CW)) bus ();

  usb32_os_event_monitor #(
    .NUM_LANES(NL), .CNT_WIDTH(CW), .RUN_THRESH(RT), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  // Reference model state: counts per type, run, wait state
  int m_cnt  [7];
  int m_snap [7];
  int m_mis, m_rtype, m_rlen, m_state, m_timer, m_target;

  task automatic model_reset();
    for (int k = 0; k < 7; k++) begin m_cnt[k] = 0; m_snap[k] = 0; end
    m_mis = 0; m_rtype = 0; m_rlen = 0; m_state = 0; m_timer = 0; m_target = 0;
  endtask

  function automatic int sat_inc(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic model_step();
    int en, val, ot, t, ty;
    bit aligned, any_v, first;
    en = int'(bus.lane_en);
    val = int'(bus.os_valid) & en;
    ot = int'(bus.os_type);
    any_v = (val != 0);
    aligned = (en != 0) && (val == en);
    t = 0;
    first = 1'b1;
    for (int i = 0; i < int'(NL); i++) begin
      if (((en >> i) & 1) == 1) begin
        ty = (ot >> (3 * i)) & 7;
        if (first) begin t = ty; first = 1'b0; end
        else if (ty != t) aligned = 1'b0;
      end
    end
    if (t < 1 || t > 6) aligned = 1'b0;

    if (bus.clr) begin
      for (int k = 1; k <= 6; k++) m_cnt[k] = 0;
      m_mis = 0; m_rtype = 0; m_rlen = 0; m_state = 0; m_timer = 0;
    end else begin
      if (aligned) begin
        m_cnt[t] = sat_inc(m_cnt[t]);
        if (t != 5) begin
          if (t == m_rtype) m_rlen = sat_inc(m_rlen);
          else begin m_rtype = t; m_rlen = 1; end
        end
      end else if (any_v) begin
        m_mis = sat_inc(m_mis);
        m_rtype = 0;
        m_rlen = 0;
      end
      if (bus.arm) begin
        m_state = 1; m_timer = 0; m_target = int'(bus.arm_target);
      end else if (m_state == 1) begin
        if (m_rtype == m_target && m_rlen >= int'(RT)) m_state = 2;
        else if (m_timer == int'(TO) - 1) m_state = 3;
        else m_timer++;
      end
    end
`ifdef USB32_OS_MON_SNAPSHOT_EN
    if (bus.clr || bus.snap) for (int k = 1; k <= 6; k++) m_snap[k] = m_cnt[k];
`endif
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 1; k <= 6; k++) begin
      chk($sformatf("cnt[%0d]", k), 64'(bus.cnt_out[(k-1)*CW +: CW]), 64'(m_cnt[k]));
      chk($sformatf("snap[%0d]", k), 64'(bus.snap_cnt[(k-1)*CW +: CW]), 64'(m_snap[k]));
    end
    chk("mismatch_cnt", 64'(bus.mismatch_cnt), 64'(m_mis));
    chk("run_type",     64'(bus.run_type),     64'(m_rtype));
    chk("run_len",      64'(bus.run_len),      64'(m_rlen));
    chk("mon_state",    64'(bus.mon_state),    64'(m_state));
    chk("target_met",   64'(bus.target_met),   64'(m_state == 2));
    chk("timeout",      64'(bus.timeout),      64'(m_state == 3));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic drive(input logic [1:0] en, input logic [1:0] vl, input logic [2:0] t0,
                       input logic [2:0] t1, input logic a, input logic [2:0] tg,
                       input logic c, input logic s);
    bus.lane_en    = en;
    bus.os_valid   = vl;
    bus.os_type    = {t1, t0};
    bus.arm        = a;
    bus.arm_target = tg;
    bus.clr        = c;
    bus.snap       = s;
  endtask

  task automatic quiet(input int n);
    drive(2'b11, 2'b00, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic both(input logic [2:0] t, input int n);
    drive(2'b11, 2'b11, t, t, 1'b0, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_clr();
    drive(2'b11, 2'b00, 3'd0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0);
    step();
  endtask

  task automatic do_arm(input logic [2:0] tg);
    drive(2'b11, 2'b00, 3'd0, 3'd0, 1'b1, tg, 1'b0, 1'b0);
    step();
  endtask

  initial begin
    logic [2:0] ct, t0, t1, tg;
    logic [1:0] en, vl;
    logic a, c, s;
    vectors = 0;
    miscompares = 0;
    model_reset();
    rst_n = 1'b0;
    drive(2'b11, 2'b00, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Eight aligned TS1 after arm
    do_clr();
    do_arm(3'd2);
    for (int i = 0; i < 8; i++) begin
      both(3'd2, 1);
      if (i == 6) chk("ts1_not_yet_met", 64'(bus.target_met), 64'd0);
    end
    chk("ts1_cnt", 64'(bus.cnt_out[1*CW +: CW]), 64'd8);
    chk("ts1_run_len", 64'(bus.run_len), 64'd8);
    chk("ts1_met", 64'(bus.target_met), 64'd1);

    // SKP is transparent to the run
    do_clr();
    do_arm(3'd2);
    both(3'd2, 4);
    both(3'd5, 2);
    both(3'd2, 4);
    chk("skp_run_len", 64'(bus.run_len), 64'd8);
    chk("skp_met", 64'(bus.mon_state), 64'd2);
    chk("skp_cnt", 64'(bus.cnt_out[4*CW +: CW]), 64'd2);

    // Lane disagreement, then same stimulus with lane1 disabled
    do_clr();
    both(3'd2, 2);
    drive(2'b11, 2'b11, 3'd2, 3'd3, 1'b0, 3'd0, 1'b0, 1'b0);
    step();
    chk("mis_cnt", 64'(bus.mismatch_cnt), 64'd1);
    chk("mis_run_len", 64'(bus.run_len), 64'd0);
    drive(2'b01, 2'b11, 3'd2, 3'd3, 1'b0, 3'd0, 1'b0, 1'b0);
    step();
    chk("lane0_ts1_cnt", 64'(bus.cnt_out[1*CW +: CW]), 64'd3);
    chk("lane0_mis_hold", 64'(bus.mismatch_cnt), 64'd1);

    // Timeout exactly TO cycles after arm
    do_clr();
    do_arm(3'd4);
    quiet(int'(TO) - 1);
    chk("to_still_armed", 64'(bus.mon_state), 64'd1);
    quiet(1);
    chk("to_fired", 64'(bus.timeout), 64'd1);
    chk("to_state", 64'(bus.mon_state), 64'd3);

    // Met on the final timer cycle wins over timeout
    do_clr();
    both(3'd4, 7);
    do_arm(3'd4);
    quiet(int'(TO) - 1);
    chk("late_armed", 64'(bus.mon_state), 64'd1);
    both(3'd4, 1);
    chk("late_met", 64'(bus.target_met), 64'd1);
    chk("late_no_to", 64'(bus.timeout), 64'd0);

    // Saturation and clr-over-arm
    do_clr();
    both(3'd4, 20);
    chk("idle_sat", 64'(bus.cnt_out[3*CW +: CW]), 64'd15);
    chk("run_sat", 64'(bus.run_len), 64'd15);
    drive(2'b11, 2'b11, 3'd4, 3'd4, 1'b1, 3'd4, 1'b1, 1'b1);
    step();
    chk("clr_arm_state", 64'(bus.mon_state), 64'd0);
    chk("clr_arm_cnt", 64'(bus.cnt_out), 64'd0);
    chk("clr_arm_snap", 64'(bus.snap_cnt), 64'd0);

    // Randomized traffic
    ct = 3'd2;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 9) == 0) ct = 3'($urandom_range(0, 7));
      en = ($urandom_range(0, 99) < 85) ? 2'b11 : 2'($urandom_range(0, 3));
      vl = ($urandom_range(0, 99) < 85) ? 2'b11 : 2'($urandom_range(0, 3));
      t0 = ct;
      t1 = ($urandom_range(0, 99) < 90) ? ct : 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 99) < 4);
      tg = ($urandom_range(0, 1) == 0) ? ct : 3'($urandom_range(1, 6));
      c  = ($urandom_range(0, 199) < 3);
      s  = ($urandom_range(0, 99) < 10);
      drive(en, vl, t0, t1, a, tg, c, s);
      step();
    end

    // Asynchronous reset mid-traffic
    do_clr();
    both(3'd3, 5);
    chk("pre_rst_cnt", 64'(bus.cnt_out[2*CW +: CW]), 64'd5);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_cnt", 64'(bus.cnt_out), 64'd0);
    chk("rst_run_len", 64'(bus.run_len), 64'd0);
    chk("rst_run_type", 64'(bus.run_type), 64'd0);
    chk("rst_state", 64'(bus.mon_state), 64'd0);
    chk("rst_mis", 64'(bus.mismatch_cnt), 64'd0);
    chk("rst_flags", 64'({bus.target_met, bus.timeout}), 64'd0);
    model_reset();
    #2;
    rst_n = 1'b1;
    step();
    both(3'd3, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
